// File: rtl/alu_execute_stage.sv
// alu_execute_stage: multi-cycle execute/write-back sequencer that sits
// directly downstream of the 4x8-bit register unit. It accepts one decoded
// instruction, reads its operands, computes a single-cycle ALU result or an
// iterative shift-add multiply, then issues a one-cycle write-back strobe.
module alu_execute_stage #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 2
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              InstrValid,
  output logic              InstrReady,
  input  logic [2:0]        Opcode,
  input  logic [REG_AW-1:0] Rd,
  input  logic [REG_AW-1:0] Rs,
  input  logic [REG_AW-1:0] Rt,
  output logic [REG_AW-1:0] ReadRegister1,
  output logic [REG_AW-1:0] ReadRegister2,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2,
  output logic              RegWrite,
  output logic [REG_AW-1:0] WriteRegister,
  output logic [DATA_W-1:0] RegWriteData,
  output logic              Zero,
  output logic              Carry,
  output logic              Busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_MUL = 3'b110,
    OP_NOP = 3'b111
  } opcode_e;

  state_e              state;
  opcode_e             op;
  logic [REG_AW-1:0]   dest;
  logic [DATA_W-1:0]   opA;
  logic [DATA_W-1:0]   opB;
  logic [DATA_W-1:0]   mulAcc;
  logic [CNT_W-1:0]    mulCnt;

  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   aluResult;
  logic                aluCarry;
  logic [DATA_W-1:0]   mulPartial;
  logic [DATA_W-1:0]   mulResult;
  logic                mulLast;
  logic [DATA_W-1:0]   execResult;

  // Handshake and status are pure decodes of the registered state.
  assign InstrReady = (state == IDLE) && !Reset;
  assign Busy       = (state != IDLE);

  // Single-cycle ALU result and carry for the latched opcode and operands.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    aluResult = '0;
    aluCarry  = Carry;
    sum       = {1'b0, opA} + {1'b0, opB};
    case (op)
      OP_ADD: begin
        aluResult = sum[DATA_W-1:0];
        aluCarry  = sum[DATA_W];
      end
      OP_SUB: begin
        aluResult = opA - opB;
        aluCarry  = (opA < opB);
      end
      OP_AND:  aluResult = opA & opB;
      OP_OR:   aluResult = opA | opB;
      OP_XOR:  aluResult = opA ^ opB;
      OP_SHL:  aluResult = opA << opB[CNT_W-1:0];
      default: aluResult = '0;
    endcase
  end

  // One shift-add step per EXEC cycle: B is scanned LSB first, overflow dropped.
  always_comb begin
    mulPartial = opB[mulCnt] ? (opA << mulCnt) : '0;
    mulResult  = mulAcc + mulPartial;
    mulLast    = (mulCnt == CNT_W'(DATA_W - 1));
    execResult = (op == OP_MUL) ? mulResult : aluResult;
  end

  // Sequencer FSM with registered read addresses, write-back and flags.
  always_ff @(posedge CLK) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (Reset) begin
      // NOTE: the operand and multiply registers are cleared together with the
      // control state so an aborted instruction leaves no stale datapath value.
      state         <= IDLE;
      op            <= OP_NOP;
      dest          <= '0;
      opA           <= '0;
      opB           <= '0;
      mulAcc        <= '0;
      mulCnt        <= '0;
      ReadRegister1 <= '0;
      ReadRegister2 <= '0;
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      RegWriteData  <= '0;
      Zero          <= 1'b0;
      Carry         <= 1'b0;
    end else begin
      RegWrite <= 1'b0;
      case (state)
        IDLE: begin
          if (InstrValid) begin
            op            <= opcode_e'(Opcode);
            dest          <= Rd;
            ReadRegister1 <= Rs;
            ReadRegister2 <= Rt;
            state         <= READ;
          end
        end
        READ: begin
          opA    <= ReadData1;
          opB    <= ReadData2;
          mulAcc <= '0;
          mulCnt <= '0;
          state  <= EXEC;
        end
        EXEC: begin
          if (op == OP_NOP) begin
            state <= IDLE;
          end else if (op == OP_MUL && !mulLast) begin
            mulAcc <= mulResult;
            mulCnt <= mulCnt + 1'b1;
          end else begin
            RegWrite      <= 1'b1;
            WriteRegister <= dest;
            RegWriteData  <= execResult;
            Zero          <= (execResult == '0);
            Carry         <= aluCarry;
            state         <= WB;
          end
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_execute_stage.sv
// tb_alu_execute_stage: directed test of the execute/write-back sequencer
// against a behavioural 4x8-bit register unit with combinational reads.
module tb_alu_execute_stage;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  logic       CLK = 1'b0;
  logic       Reset;
  logic       InstrValid;
  logic       InstrReady;
  logic [2:0] Opcode;
  logic [1:0] Rd, Rs, Rt;
  logic [1:0] ReadRegister1, ReadRegister2;
  logic [7:0] ReadData1, ReadData2;
  logic       RegWrite;
  logic [1:0] WriteRegister;
  logic [7:0] RegWriteData;
  logic       Zero, Carry, Busy;

  int assertions = 0;
  int failures   = 0;

  logic [7:0] regs [4];
  logic       tbWrEn;
  logic [1:0] tbWrAddr;
  logic [7:0] tbWrData;

  alu_execute_stage #(.DATA_W(8), .REG_AW(2)) dut (
    .CLK(CLK), .Reset(Reset), .InstrValid(InstrValid), .InstrReady(InstrReady),
    .Opcode(Opcode), .Rd(Rd), .Rs(Rs), .Rt(Rt),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .RegWriteData(RegWriteData),
    .Zero(Zero), .Carry(Carry), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  // Register unit model: combinational reads, write on the clock edge.
  assign ReadData1 = regs[ReadRegister1];
  assign ReadData2 = regs[ReadRegister2];

  always @(posedge CLK) begin
    if (RegWrite) regs[WriteRegister] <= RegWriteData;
    else if (tbWrEn) regs[tbWrAddr] <= tbWrData;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertions++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic preload(input logic [1:0] addr, input logic [7:0] data);
    tbWrEn = 1'b1; tbWrAddr = addr; tbWrData = data;
    tick();
    tbWrEn = 1'b0;
  endtask

  // Issue one instruction and follow it cycle by cycle through write-back.
  task automatic runOp(input string tag, input logic [2:0] op, input logic [1:0] rd,
                       input logic [1:0] rs, input logic [1:0] rt, input int execCycles,
                       input logic [7:0] expData, input logic expZero, input logic expCarry);
    check({tag, "_ready"}, InstrReady, 1);
    Opcode = op; Rd = rd; Rs = rs; Rt = rt; InstrValid = 1'b1;
    tick();                                   // E0
    InstrValid = 1'b0; Opcode = ~op; Rd = ~rd; Rs = ~rs; Rt = ~rt;
    check({tag, "_busy"}, Busy, 1);
    check({tag, "_rr1"}, ReadRegister1, rs);
    check({tag, "_rr2"}, ReadRegister2, rt);
    for (int i = 0; i < execCycles; i++) begin
      tick();                                 // E1 .. E(execCycles)
      check({tag, "_early_wr"}, RegWrite, 0);
      check({tag, "_busy_exec"}, Busy, 1);
    end
    tick();                                   // write-back cycle
    check({tag, "_wr"}, RegWrite, 1);
    check({tag, "_waddr"}, WriteRegister, rd);
    check({tag, "_data"}, RegWriteData, expData);
    check({tag, "_zero"}, Zero, expZero);
    check({tag, "_carry"}, Carry, expCarry);
    tick();                                   // back in IDLE
    check({tag, "_wr_end"}, RegWrite, 0);
    check({tag, "_idle"}, Busy, 0);
    check({tag, "_regfile"}, regs[rd], expData);
  endtask

  initial begin
    int wrSeen;
    Reset = 1'b1; InstrValid = 1'b0; Opcode = '0; Rd = '0; Rs = '0; Rt = '0;
    tbWrEn = 1'b0; tbWrAddr = '0; tbWrData = '0;
    tick(); tick();

    // Reset state.
    check("rst_ready", InstrReady, 0);
    check("rst_busy", Busy, 0);
    check("rst_wr", RegWrite, 0);
    check("rst_waddr", WriteRegister, 0);
    check("rst_wdata", RegWriteData, 0);
    check("rst_rr1", ReadRegister1, 0);
    check("rst_rr2", ReadRegister2, 0);
    check("rst_zero", Zero, 0);
    check("rst_carry", Carry, 0);
    Reset = 1'b0;
    #1;
    check("rst_ready_after", InstrReady, 1);

    // Basic ADD, SUB with borrow, ADD wrapping to zero.
    preload(2'd1, 8'h05); preload(2'd2, 8'h03);
    runOp("add", OP_ADD, 2'd3, 2'd1, 2'd2, 1, 8'h08, 1'b0, 1'b0);
    preload(2'd1, 8'h03); preload(2'd2, 8'h05);
    runOp("sub", OP_SUB, 2'd0, 2'd1, 2'd2, 1, 8'hFE, 1'b0, 1'b1);
    preload(2'd1, 8'hFF); preload(2'd2, 8'h01);
    runOp("add_wrap", OP_ADD, 2'd3, 2'd1, 2'd2, 1, 8'h00, 1'b1, 1'b1);

    // NOP: no write-back, flags and write-back outputs hold.
    check("nop_ready", InstrReady, 1);
    Opcode = OP_NOP; Rd = 2'd2; Rs = 2'd1; Rt = 2'd2; InstrValid = 1'b1;
    tick();
    InstrValid = 1'b0;
    check("nop_busy", Busy, 1);
    tick();
    check("nop_wr_e1", RegWrite, 0);
    tick();
    check("nop_wr_e2", RegWrite, 0);
    check("nop_ready_e2", InstrReady, 1);
    check("nop_zero", Zero, 1);
    check("nop_carry", Carry, 1);
    check("nop_waddr_hold", WriteRegister, 3);
    check("nop_wdata_hold", RegWriteData, 8'h00);
    check("nop_regfile", regs[2], 8'h01);

    // MUL: write-back at E9, Carry untouched.
    preload(2'd1, 8'h0F); preload(2'd2, 8'h11);
    runOp("mul", OP_MUL, 2'd3, 2'd1, 2'd2, 8, 8'hFF, 1'b0, 1'b1);
    preload(2'd1, 8'h20); preload(2'd2, 8'h10);
    runOp("mul_ovf", OP_MUL, 2'd2, 2'd1, 2'd2, 8, 8'h00, 1'b1, 1'b1);

    // Logic ops and shift amount taken from B[2:0] only.
    preload(2'd1, 8'hF0); preload(2'd2, 8'h3C);
    runOp("and", OP_AND, 2'd3, 2'd1, 2'd2, 1, 8'h30, 1'b0, 1'b1);
    runOp("or",  OP_OR,  2'd3, 2'd1, 2'd2, 1, 8'hFC, 1'b0, 1'b1);
    runOp("xor", OP_XOR, 2'd0, 2'd1, 2'd2, 1, 8'hCC, 1'b0, 1'b1);
    preload(2'd1, 8'h81); preload(2'd2, 8'h09);
    runOp("shl", OP_SHL, 2'd2, 2'd1, 2'd2, 1, 8'h02, 1'b0, 1'b1);

    // Dependent pair with InstrValid held high across the first instruction.
    preload(2'd1, 8'h02); preload(2'd2, 8'h06);
    check("dep_ready", InstrReady, 1);
    Opcode = OP_ADD; Rd = 2'd3; Rs = 2'd1; Rt = 2'd2; InstrValid = 1'b1;
    tick();                                   // E0
    Opcode = OP_SHL; Rd = 2'd0; Rs = 2'd3; Rt = 2'd1;
    check("dep_ready_e0", InstrReady, 0);
    check("dep_rr1_e0", ReadRegister1, 1);
    tick();                                   // E1
    check("dep_ready_e1", InstrReady, 0);
    tick();                                   // E2
    check("dep_ready_e2", InstrReady, 0);
    check("dep_add_wr", RegWrite, 1);
    check("dep_add_data", RegWriteData, 8'h08);
    check("dep_add_carry", Carry, 0);
    tick();                                   // E3
    check("dep_ready_e3", InstrReady, 1);
    check("dep_add_reg", regs[3], 8'h08);
    tick();                                   // E4: SHL accepted
    InstrValid = 1'b0;
    check("dep_shl_busy", Busy, 1);
    check("dep_shl_rr1", ReadRegister1, 3);
    check("dep_shl_rr2", ReadRegister2, 1);
    tick(); tick();                           // E5, E6
    check("dep_shl_wr", RegWrite, 1);
    check("dep_shl_waddr", WriteRegister, 0);
    check("dep_shl_data", RegWriteData, 8'h20);
    check("dep_shl_zero", Zero, 0);
    check("dep_shl_carry", Carry, 0);
    tick();                                   // E7
    check("dep_shl_reg", regs[0], 8'h20);
    check("dep_idle", Busy, 0);

    // Reset during MUL EXEC aborts the instruction.
    preload(2'd1, 8'hFF); preload(2'd2, 8'h01);
    runOp("pre_abort", OP_ADD, 2'd3, 2'd1, 2'd2, 1, 8'h00, 1'b1, 1'b1);
    preload(2'd1, 8'h0F); preload(2'd2, 8'h11);
    Opcode = OP_MUL; Rd = 2'd0; Rs = 2'd1; Rt = 2'd2; InstrValid = 1'b1;
    tick();                                   // E0
    InstrValid = 1'b0;
    wrSeen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();                                 // E1 .. E4
      if (RegWrite) wrSeen++;
    end
    Reset = 1'b1;
    #1;
    check("abort_ready_in_reset", InstrReady, 0);
    tick();                                   // E5 with Reset sampled
    check("abort_busy", Busy, 0);
    check("abort_zero", Zero, 0);
    check("abort_carry", Carry, 0);
    check("abort_wr", RegWrite, 0);
    Reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (RegWrite) wrSeen++;
    end
    check("abort_no_writeback", wrSeen, 0);
    check("abort_reg_kept", regs[0], 8'h20);
    runOp("post_abort", OP_ADD, 2'd1, 2'd1, 2'd2, 1, 8'h20, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/alu_execute_stage.md
Name: alu_execute_stage

Overview:
- Multi-cycle execute/write-back sequencer sitting directly downstream of the 4x8-bit register unit.
- Accepts one decoded instruction through a valid/ready handshake.
- Drives the register unit's read addresses and captures the returned operands.
- Computes the result (single-cycle ALU op or 8-cycle iterative multiply), then issues a one-cycle write-back that the register unit consumes on its next CLK edge.

Parameters:
- DATA_W, 8: operand/result width; also the number of MUL iteration cycles.
- REG_AW, 2: register address width (4 registers).

Ports:
- CLK  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high reset
- InstrValid  in  1  instruction fields valid
- InstrReady  out  1  block can accept an instruction (high only in IDLE)
- Opcode  in  3  operation select (see Behaviour)
- Rd  in  REG_AW  destination register
- Rs  in  REG_AW  source register A
- Rt  in  REG_AW  source register B
- ReadRegister1  out  REG_AW  to register unit, address for A
- ReadRegister2  out  REG_AW  to register unit, address for B
- ReadData1  in  DATA_W  from register unit, value of A (combinational read)
- ReadData2  in  DATA_W  from register unit, value of B
- RegWrite  out  1  write-back strobe to register unit
- WriteRegister  out  REG_AW  write-back address
- RegWriteData  out  DATA_W  write-back data
- Zero  out  1  last result == 0
- Carry  out  1  ADD carry-out / SUB borrow
- Busy  out  1  high whenever state != IDLE

Behaviour:
- Interface (already decided): one clock CLK; Reset is synchronous and active-high.
- Reset: state=IDLE; RegWrite=0; WriteRegister=0; RegWriteData=0; ReadRegister1/2=0; Zero=0; Carry=0; Busy=0. While Reset is high, InstrReady=0 and no handshake is accepted.
- Reset mid-operation aborts the instruction: no RegWrite is issued and flags go to 0.
- Handshake: accept on a rising edge where InstrValid && InstrReady.
  - Opcode/Rd/Rs/Rt latch internally at that edge; inputs are don't-care afterwards.
  - InstrReady is combinationally (state==IDLE && !Reset).
- States:
  - IDLE -> READ on accept.
  - READ: ReadRegister1=latched Rs, ReadRegister2=latched Rt (registered outputs, valid from the accept edge). Capture A=ReadData1, B=ReadData2 at the end of READ. Go to EXEC.
  - EXEC: non-MUL ops complete in 1 cycle. MUL runs exactly DATA_W cycles: shift-add with a 3-bit counter over B bits LSB first, 8-bit accumulator, overflow bits discarded. Go to WB, or IDLE for NOP.
  - WB: RegWrite=1 for exactly one cycle with WriteRegister=latched Rd and RegWriteData=result. Then IDLE.
- Opcodes:
  - 000 ADD: A+B; Carry = bit 8 of the sum.
  - 001 SUB: A-B mod 256; Carry = (A<B).
  - 010 AND; 011 OR; 100 XOR.
  - 101 SHL: A << B[2:0], zero fill.
  - 110 MUL: low 8 bits of A*B.
  - 111 NOP: no WB; flags unchanged.
- Flags: update on the EXEC->WB transition.
  - Zero = (result==0) for every non-NOP op.
  - Carry updates only for ADD/SUB and holds otherwise.
- Latency, with accept at edge E0:
  - ALU ops: RegWrite high between E2 and E3, register written at E3, InstrReady high after E3.
  - MUL: RegWrite high between E9 and E10.
  - NOP: back in IDLE after E2.
- Write-back outputs hold their last value when RegWrite=0.
- Back-to-back dependency needs no forwarding: a following instruction's READ occurs after the previous WB edge has updated the register file.
- Rd==Rs or Rd==Rt is legal; operands are captured before the write.

Test Plan:
- R1=0x05, R2=0x03; ADD Rd=3,Rs=1,Rt=2 -> RegWrite pulse 1 cycle at E2..E3, WriteRegister=3, data 0x08, Zero=0, Carry=0; R3 reads 0x08 afterwards.
- R1=0x03, R2=0x05; SUB Rd=0 -> data 0xFE, Carry=1. Then ADD of 0xFF+0x01 -> 0x00, Zero=1, Carry=1.
- MUL 0x0F*0x11 -> 0xFF with RegWrite exactly at E9..E10 and Busy high E0..E10. MUL 0x20*0x10 -> 0x00, Zero=1, Carry unchanged.
- Dependent pair: ADD R3=R1+R2 (0x08), then immediately SHL R0=R3<<R1 with R1=0x02 -> 0x20; InstrReady low while busy, and an InstrValid held high is accepted only after E3.
- NOP: no RegWrite, flags unchanged, InstrReady returns after E2. AND/OR/XOR on 0xF0,0x3C -> 0x30/0xFC/0xCC.
- Assert Reset during MUL EXEC cycle 4 -> no RegWrite ever, Busy=0 and flags=0 next cycle, target register unchanged; a new ADD accepted after Reset deasserts completes normally.
